data_memory_unit: RTL and testbench

- Parametrised single-port data memory for the 16-bit datapath, and the next generation of the processor's combinational data memory.
- Reads are registered with a 1-cycle `read_valid` strobe. Writes commit on the clock edge.
- A built-in clear engine zeroes the whole array after every reset. A `ready` flag gates all accesses.
- Sits between the ALU address path and the register-file writeback mux.

---
 rtl/data_memory_unit_pkg.sv | 19 +
 rtl/data_memory_unit_mem_array.sv | 38 +++
 rtl/data_memory_unit.sv | 113 +++++++++++
 tb/tb_data_memory_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared types and defaults for the data memory unit.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } memState_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 256;

    function automatic int idxWidth(input int depth);
        return $clog2(depth);
    endfunction

    localparam int IDX_W_DEF = idxWidth(DEPTH_DEF);

endpackage

// File: rtl/data_memory_unit_mem_array.sv
// 1-write/1-read synchronous storage with read-before-write and a registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = idxWidth(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic              rdZero,
    input  logic [IDX_W-1:0]  rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; the clear engine zeroes it instead.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // NOTE: non-blocking assignments make a same-edge read see the pre-write contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= rdZero ? '0 : mem[rdAddr];
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Single-port data memory with post-reset clear engine and registered reads.
// Optional out-of-range detection is enabled by defining MEM_BOUNDS_CHECK_EN.
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic              addr_err,
`endif
    output logic              ready
);

    localparam int IDX_W = idxWidth(DEPTH);

    memState_e        state, nextState;
    logic [IDX_W-1:0] clearPtr;
    logic [IDX_W-1:0] index;
    logic             accRead, accWrite, outOfRange;
    logic             wrEn;
    logic [IDX_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;

    assign ready    = (state == IDLE);
    assign accRead  = ready & mem_read;
    assign accWrite = ready & mem_write;
    // Truncating cast drops the upper address bits so they alias in the default build.
    assign index    = IDX_W'(address);

`ifdef MEM_BOUNDS_CHECK_EN
    assign outOfRange = ({1'b0, address} >= (ADDR_W + 1)'(DEPTH));
`else
    assign outOfRange = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= CLEAR;
            clearPtr <= '0;
        end else begin
            state <= nextState;
            if (state == CLEAR) begin
                clearPtr <= clearPtr + IDX_W'(1);
            end
        end
    end

    // NOTE: nextState gets a default first so no path through the case infers a latch.
    always_comb begin
        nextState = state;
        case (state)
            CLEAR:   if (clearPtr == IDX_W'(DEPTH - 1)) nextState = IDLE;
            IDLE:    nextState = IDLE;
            default: nextState = CLEAR;
        endcase
    end

    always_comb begin
        wrEn   = accWrite & ~outOfRange;
        wrAddr = index;
        wrData = write_data;
        if (state == CLEAR) begin
            wrEn   = 1'b1;
            wrAddr = clearPtr;
            wrData = '0;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock  (clock),
        .reset  (reset),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdEn   (accRead),
        .rdZero (outOfRange),
        .rdAddr (index),
        .rdData (read_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_valid <= 1'b0;
        end else begin
            read_valid <= accRead;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (accRead | accWrite) & outOfRange;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit; honours MEM_BOUNDS_CHECK_EN.
module tb_data_memory_unit;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_valid;
    logic        ready;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        addr_err;
`endif

    int checks = 0;
    int errors = 0;
    int cycles;
    logic sawValid;

    data_memory_unit dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
`ifdef MEM_BOUNDS_CHECK_EN
        .addr_err   (addr_err),
`endif
        .ready      (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one request, then sample just after the edge that accepts it.
    task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic waitReady(input string tag);
        cycles   = 0;
        sawValid = 1'b0;
        while (!ready && cycles < 400) begin
            @(posedge clock);
            #1;
            cycles++;
            if (read_valid) sawValid = 1'b1;
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_clear_len"}, 32'(cycles), 32'd256);
        check({tag, "_no_valid_in_clear"}, 32'(sawValid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_data", 32'(read_data), 32'h0);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
        check("rst_err", 32'(addr_err), 32'd0);
`endif

        // Reads held during CLEAR must be ignored.
        reset    = 1'b0;
        mem_read = 1'b1;
        address  = 16'd5;
        waitReady("clr1");
        step(1'b1, 1'b0, 16'd5, 16'h0);
        check("rd5_valid", 32'(read_valid), 32'd1);
        check("rd5_data", 32'(read_data), 32'h0);

        step(1'b0, 1'b1, 16'h0012, 16'hBEEF);
        check("wr_no_valid", 32'(read_valid), 32'd0);
        check("wr_hold_data", 32'(read_data), 32'h0);
        step(1'b1, 1'b0, 16'h0012, 16'h0);
        check("rd12_valid", 32'(read_valid), 32'd1);
        check("rd12_data", 32'(read_data), 32'hBEEF);
        step(1'b0, 1'b0, 16'h0, 16'h0);
        check("pulse_end", 32'(read_valid), 32'd0);
        check("data_hold", 32'(read_data), 32'hBEEF);

        // Same-index read and write returns the old word.
        step(1'b0, 1'b1, 16'd7, 16'h1111);
        step(1'b1, 1'b1, 16'd7, 16'h2222);
        check("rbw_old", 32'(read_data), 32'h1111);
        check("rbw_valid", 32'(read_valid), 32'd1);
        step(1'b1, 1'b0, 16'd7, 16'h0);
        check("rbw_new", 32'(read_data), 32'h2222);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'(i), 16'h0);
            check($sformatf("stream%0d_valid", i), 32'(read_valid), 32'd1);
            check($sformatf("stream%0d_data", i), 32'(read_data), 32'hA000 + 32'(i));
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        check("stream_end", 32'(read_valid), 32'd0);

        step(1'b0, 1'b1, 16'h0105, 16'h3333);
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_wr_err", 32'(addr_err), 32'd1);
        step(1'b1, 1'b0, 16'd5, 16'h0);
        check("oob_err_clear", 32'(addr_err), 32'd0);
        check("oob_arr5", 32'(read_data), 32'h0);
        step(1'b1, 1'b0, 16'h0105, 16'h0);
        check("oob_rd_err", 32'(addr_err), 32'd1);
        check("oob_rd_valid", 32'(read_valid), 32'd1);
        check("oob_rd_data", 32'(read_data), 32'h0);
`else
        step(1'b1, 1'b0, 16'd5, 16'h0);
        check("alias_arr5", 32'(read_data), 32'h3333);
`endif

        // Asynchronous reset while a read result is being presented.
        step(1'b1, 1'b0, 16'h0012, 16'h0);
        check("pre_rst_valid", 32'(read_valid), 32'd1);
        check("pre_rst_data", 32'(read_data), 32'hBEEF);
        mem_read = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_data", 32'(read_data), 32'h0);
        check("async_valid", 32'(read_valid), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        waitReady("clr2");
        step(1'b1, 1'b0, 16'h0012, 16'h0);
        check("post_rst_valid", 32'(read_valid), 32'd1);
        check("post_rst_data", 32'(read_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
